// File: rtl/call_line_arbiter.sv
// call_line_arbiter
//   Shares one telephone call core between N subscriber lines. A round-robin
//   arbiter picks a requesting line, pulses start_call, then multiplexes the
//   owner's traffic and the callee port onto the core inputs until the call
//   ends, the hold budget runs out, or the core drops back to "IDLE    ".
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   line_req[N]               level call request per line
//   line_send/line_hangup[N]  per-line strobes, line_char[8N] per-line chars
//   callee_*                  callee-side strobes and character
//   core_status[64]           8 ASCII chars from the core, MSB char first
//   grant[N]                  one-hot owner of the core (0 when free)
//   line_ack[N], callee_ack   1-cycle "character forwarded" pulses
//   start_call..send_callee   core control strobes, char_out to the core
//   err                       1-cycle pulse on ring or drain timeout
//   calls_done[16]            saturating count of sessions that were reached
module call_line_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 255,
    parameter int RING_TO  = 4,
    parameter int DRAIN_TO = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   line_req,
    input  logic [N-1:0]   line_send,
    input  logic [8*N-1:0] line_char,
    input  logic [N-1:0]   line_hangup,
    input  logic           callee_answer,
    input  logic           callee_reject,
    input  logic           callee_hangup,
    input  logic           callee_send,
    input  logic [7:0]     callee_char,
    input  logic [63:0]    core_status,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   line_ack,
    output logic           callee_ack,
    output logic           start_call,
    output logic           answer_call,
    output logic           end_caller,
    output logic           end_callee,
    output logic           send_caller,
    output logic           send_callee,
    output logic [7:0]     char_out,
    output logic           err,
    output logic [15:0]    calls_done
);

    localparam int          PW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [63:0] IDLE_STR   = 64'h49444C4520202020;
    localparam logic [15:0] HOLD_LAST  = 16'(HOLD_MAX);
    localparam logic [15:0] RING_LAST  = 16'(RING_TO - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TO - 1);

    typedef enum logic [2:0] {
        S_ARB, S_LAUNCH, S_WAIT_RING, S_SESSION, S_DRAIN, S_RELEASE
    } state_t;

    state_t        state_q;
    logic [PW-1:0] ptr_q, gidx_q;
    logic [15:0]   timer_q;      // ring, hold and drain timer; states are exclusive
    logic          sess_seen_q;  // SESSION was reached during this grant
    logic [N-1:0]  grant_q, line_ack_q;
    logic          callee_ack_q, start_q, ans_q, endr_q, ende_q, sndr_q, snde_q;
    logic [7:0]    char_q;
    logic          err_q;
    logic [15:0]   done_q;

    logic          core_idle;
    assign core_idle = (core_status == IDLE_STR);

    // Round-robin pick: first requester at or above the pointer, wrapping.
    logic [PW-1:0] win_d;
    logic [N-1:0]  win_oh_d;
    logic          found;
    int            idx;
    always_comb begin
        win_d    = '0;
        win_oh_d = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && line_req[idx]) begin
                found         = 1'b1;
                win_d         = PW'(idx);
                win_oh_d      = '0;
                win_oh_d[idx] = 1'b1;
            end
        end
    end

    // Session decode for the granted line.
    logic       g_send, g_hang, g_req;
    logic [7:0] g_char;
    logic       endr_d, ende_d, any_end, sndr_d, snde_d;
    logic [PW-1:0] ptr_nxt_d;
    always_comb begin
        g_send    = line_send[gidx_q];
        g_hang    = line_hangup[gidx_q];
        g_req     = line_req[gidx_q];
        g_char    = line_char[8*gidx_q +: 8];
        endr_d    = g_hang | ~g_req | (timer_q == HOLD_LAST);
        ende_d    = callee_hangup | callee_reject;
        any_end   = endr_d | ende_d;
        // A hangup kills any send in the same cycle; the caller beats the callee.
        sndr_d    = g_send & ~any_end;
        snde_d    = callee_send & ~g_send & ~any_end;
        ptr_nxt_d = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_ARB;
            ptr_q        <= '0;
            gidx_q       <= '0;
            timer_q      <= '0;
            sess_seen_q  <= 1'b0;
            grant_q      <= '0;
            line_ack_q   <= '0;
            callee_ack_q <= 1'b0;
            start_q      <= 1'b0;
            ans_q        <= 1'b0;
            endr_q       <= 1'b0;
            ende_q       <= 1'b0;
            sndr_q       <= 1'b0;
            snde_q       <= 1'b0;
            char_q       <= '0;
            err_q        <= 1'b0;
            done_q       <= '0;
        end else begin
            // Strobe outputs are single-cycle unless re-asserted below.
            line_ack_q   <= '0;
            callee_ack_q <= 1'b0;
            start_q      <= 1'b0;
            ans_q        <= 1'b0;
            endr_q       <= 1'b0;
            ende_q       <= 1'b0;
            sndr_q       <= 1'b0;
            snde_q       <= 1'b0;
            char_q       <= '0;
            err_q        <= 1'b0;
            case (state_q)
                S_ARB: begin
                    if (found) begin
                        gidx_q      <= win_d;
                        grant_q     <= win_oh_d;
                        sess_seen_q <= 1'b0;
                        timer_q     <= '0;
                        state_q     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    start_q <= 1'b1;
                    timer_q <= '0;
                    state_q <= S_WAIT_RING;
                end
                S_WAIT_RING: begin
                    if (!core_idle) begin
                        timer_q     <= '0;
                        sess_seen_q <= 1'b1;
                        state_q     <= S_SESSION;
                    end else if (timer_q == RING_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_RELEASE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_SESSION: begin
                    ans_q  <= callee_answer;
                    endr_q <= endr_d;
                    ende_q <= ende_d;
                    sndr_q <= sndr_d;
                    snde_q <= snde_d;
                    if (sndr_d) begin
                        char_q     <= g_char;
                        line_ack_q <= grant_q;
                    end else if (snde_d) begin
                        char_q       <= callee_char;
                        callee_ack_q <= 1'b1;
                    end
                    timer_q <= timer_q + 16'd1;
                    // Core returning to IDLE by itself also ends the session.
                    if (any_end || core_idle) begin
                        timer_q <= '0;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (core_idle) begin
                        state_q <= S_RELEASE;
                    end else if (timer_q == DRAIN_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= S_RELEASE;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                S_RELEASE: begin
                    grant_q <= '0;
                    ptr_q   <= ptr_nxt_d;
                    if (sess_seen_q && done_q != 16'hFFFF)
                        done_q <= done_q + 16'd1;
                    state_q <= S_ARB;
                end
                default: state_q <= S_ARB;
            endcase
        end
    end

    assign grant       = grant_q;
    assign line_ack    = line_ack_q;
    assign callee_ack  = callee_ack_q;
    assign start_call  = start_q;
    assign answer_call = ans_q;
    assign end_caller  = endr_q;
    assign end_callee  = ende_q;
    assign send_caller = sndr_q;
    assign send_callee = snde_q;
    assign char_out    = char_q;
    assign err         = err_q;
    assign calls_done  = done_q;

endmodule

// File: tb/tb_call_line_arbiter.sv
// Scoreboard bench for call_line_arbiter: expectations are queued while the
// stimulus for the next edge is driven, then popped and compared #1 after it.
module tb_call_line_arbiter;

    localparam logic [63:0] IDLE_S = 64'h49444C4520202020;
    localparam logic [63:0] RING_S = "RINGING ";
    localparam logic [63:0] CALL_S = "CALLER  ";

    // ctrl = {start, answer, end_caller, end_callee, send_caller, send_callee}
    localparam logic [5:0] C_START = 6'b100000;
    localparam logic [5:0] C_ANS   = 6'b010000;
    localparam logic [5:0] C_ENDR  = 6'b001000;
    localparam logic [5:0] C_ENDE  = 6'b000100;
    localparam logic [5:0] C_SNDR  = 6'b000010;
    localparam logic [5:0] C_SNDE  = 6'b000001;

    localparam int S_GRANT = 0, S_LACK = 1, S_CACK = 2, S_CTRL = 3,
                   S_CHAR = 4, S_ERR = 5, S_DONE = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  line_req, line_send, line_hangup;
    logic [31:0] line_char;
    logic        callee_answer, callee_reject, callee_hangup, callee_send;
    logic [7:0]  callee_char;
    logic [63:0] core_status;
    logic [3:0]  grant, line_ack;
    logic        callee_ack, start_call, answer_call, end_caller, end_callee;
    logic        send_caller, send_callee, err;
    logic [7:0]  char_out;
    logic [15:0] calls_done;

    call_line_arbiter #(.N(4), .HOLD_MAX(8), .RING_TO(4), .DRAIN_TO(32)) dut (
        .clk(clk), .rst(rst),
        .line_req(line_req), .line_send(line_send), .line_char(line_char),
        .line_hangup(line_hangup),
        .callee_answer(callee_answer), .callee_reject(callee_reject),
        .callee_hangup(callee_hangup), .callee_send(callee_send),
        .callee_char(callee_char), .core_status(core_status),
        .grant(grant), .line_ack(line_ack), .callee_ack(callee_ack),
        .start_call(start_call), .answer_call(answer_call),
        .end_caller(end_caller), .end_callee(end_callee),
        .send_caller(send_caller), .send_callee(send_callee),
        .char_out(char_out), .err(err), .calls_done(calls_done)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] obs(input int sel);
        logic [63:0] r;
        case (sel)
            S_GRANT: r = 64'(grant);
            S_LACK:  r = 64'(line_ack);
            S_CACK:  r = 64'(callee_ack);
            S_CTRL:  r = 64'({start_call, answer_call, end_caller, end_callee,
                              send_caller, send_callee});
            S_CHAR:  r = 64'(char_out);
            S_ERR:   r = 64'(err);
            S_DONE:  r = 64'(calls_done);
            default: r = '1;
        endcase
        return r;
    endfunction

    task automatic sb_push(input string tag, input int sel, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic sb_drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sb_drain();
    endtask

    // ARB edge grants g, LAUNCH edge raises start_call.
    task automatic launch(input logic [3:0] g);
        sb_push("arb_grant", S_GRANT, 64'(g));
        sb_push("arb_ctrl", S_CTRL, 64'(6'b0));
        step();
        sb_push("launch_start", S_CTRL, 64'(C_START));
        sb_push("launch_grant", S_GRANT, 64'(g));
        step();
    endtask

    // Status scripted IDLE -> RINGING -> CALLER -> IDLE, no strobes.
    task automatic rr_session(input logic [3:0] g, input int done_after);
        launch(g);
        core_status = RING_S;
        sb_push("rr_ring_ctrl", S_CTRL, 64'(6'b0));
        step();
        core_status = CALL_S;
        sb_push("rr_sess_ctrl", S_CTRL, 64'(6'b0));
        step();
        core_status = IDLE_S;
        sb_push("rr_idle_ctrl", S_CTRL, 64'(6'b0));
        step();
        sb_push("rr_drain_grant", S_GRANT, 64'(g));
        step();
        sb_push("rr_rel_grant", S_GRANT, 64'(0));
        sb_push("rr_calls_done", S_DONE, 64'(done_after));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] g;
        rst = 1'b1;
        line_req = '0; line_send = '0; line_hangup = '0; line_char = '0;
        callee_answer = 1'b0; callee_reject = 1'b0; callee_hangup = 1'b0;
        callee_send = 1'b0; callee_char = '0;
        core_status = IDLE_S;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        sb_push("rst_grant", S_GRANT, 64'(0));
        sb_push("rst_ctrl", S_CTRL, 64'(6'b0));
        sb_push("rst_lack", S_LACK, 64'(0));
        sb_push("rst_cack", S_CACK, 64'(0));
        sb_push("rst_char", S_CHAR, 64'(0));
        sb_push("rst_err", S_ERR, 64'(0));
        sb_push("rst_done", S_DONE, 64'(0));
        sb_drain();
        rst = 1'b0;

        // Round robin with all lines requesting.
        line_req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << (k % 4);
            rr_session(g, k + 1);
        end
        line_req = '0;

        // Contention on line 2 (pointer is now 1).
        line_req = 4'b0100;
        launch(4'b0100);
        core_status = RING_S;
        sb_push("ct_ring_ctrl", S_CTRL, 64'(6'b0));
        step();
        core_status = CALL_S;
        line_send = 4'b0100; line_char = 32'h0041_0000;
        callee_send = 1'b1; callee_char = 8'h62;
        sb_push("ct_caller_ctrl", S_CTRL, 64'(C_SNDR));
        sb_push("ct_caller_char", S_CHAR, 64'h41);
        sb_push("ct_caller_lack", S_LACK, 64'(4'b0100));
        sb_push("ct_caller_cack", S_CACK, 64'(0));
        step();
        line_send = '0;
        sb_push("ct_callee_ctrl", S_CTRL, 64'(C_SNDE));
        sb_push("ct_callee_char", S_CHAR, 64'h62);
        sb_push("ct_callee_cack", S_CACK, 64'(1));
        sb_push("ct_callee_lack", S_LACK, 64'(0));
        step();
        callee_send = 1'b0;
        line_send = 4'b0001; line_char = 32'h0041_005A;
        sb_push("ng_ctrl", S_CTRL, 64'(6'b0));
        sb_push("ng_lack", S_LACK, 64'(0));
        step();
        line_send = '0; callee_answer = 1'b1;
        sb_push("answer_ctrl", S_CTRL, 64'(C_ANS));
        step();
        callee_answer = 1'b0;
        line_hangup = 4'b0100; callee_hangup = 1'b1; line_send = 4'b0100;
        sb_push("hang_ctrl", S_CTRL, 64'(C_ENDR | C_ENDE));
        sb_push("hang_lack", S_LACK, 64'(0));
        sb_push("hang_cack", S_CACK, 64'(0));
        step();
        line_hangup = '0; callee_hangup = 1'b0; line_send = '0;
        sb_push("hang_drain_ctrl", S_CTRL, 64'(6'b0));
        sb_push("hang_drain_grant", S_GRANT, 64'(4'b0100));
        step();
        core_status = IDLE_S;
        sb_push("hang_idle_grant", S_GRANT, 64'(4'b0100));
        sb_push("hang_idle_err", S_ERR, 64'(0));
        step();
        sb_push("hang_rel_grant", S_GRANT, 64'(0));
        sb_push("hang_rel_done", S_DONE, 64'(6));
        step();

        // Ring timeout on line 3: core never leaves IDLE.
        line_req = 4'b1000;
        launch(4'b1000);
        for (int k = 0; k < 3; k++) begin
            sb_push("rto_err_early", S_ERR, 64'(0));
            sb_push("rto_ctrl", S_CTRL, 64'(6'b0));
            step();
        end
        sb_push("rto_err", S_ERR, 64'(1));
        sb_push("rto_grant_held", S_GRANT, 64'(4'b1000));
        step();
        line_req = '0;
        sb_push("rto_rel_grant", S_GRANT, 64'(0));
        sb_push("rto_rel_err", S_ERR, 64'(0));
        sb_push("rto_done", S_DONE, 64'(6));
        step();

        // Hold budget on line 1 (pointer is now 0).
        line_req = 4'b0010;
        launch(4'b0010);
        core_status = RING_S;
        sb_push("hold_ring_ctrl", S_CTRL, 64'(6'b0));
        step();
        core_status = CALL_S;
        for (int k = 0; k < 8; k++) begin
            sb_push("hold_quiet_ctrl", S_CTRL, 64'(6'b0));
            step();
        end
        sb_push("hold_end_ctrl", S_CTRL, 64'(C_ENDR));
        step();
        sb_push("hold_drain_ctrl", S_CTRL, 64'(6'b0));
        sb_push("hold_drain_grant", S_GRANT, 64'(4'b0010));
        step();
        core_status = IDLE_S;
        sb_push("hold_idle_grant", S_GRANT, 64'(4'b0010));
        step();
        sb_push("hold_rel_grant", S_GRANT, 64'(0));
        sb_push("hold_done", S_DONE, 64'(7));
        step();

        // Reset mid-session on line 2 (pointer is now 2).
        line_req = 4'b0100;
        launch(4'b0100);
        core_status = RING_S;
        sb_push("mrst_ring_ctrl", S_CTRL, 64'(6'b0));
        step();
        core_status = CALL_S;
        callee_send = 1'b1; callee_char = 8'h33;
        sb_push("mrst_snd_ctrl", S_CTRL, 64'(C_SNDE));
        sb_push("mrst_snd_cack", S_CACK, 64'(1));
        step();
        #2;
        rst = 1'b1;
        #1;
        sb_push("mrst_grant", S_GRANT, 64'(0));
        sb_push("mrst_ctrl", S_CTRL, 64'(6'b0));
        sb_push("mrst_cack", S_CACK, 64'(0));
        sb_push("mrst_done", S_DONE, 64'(0));
        sb_push("mrst_err", S_ERR, 64'(0));
        sb_drain();
        callee_send = 1'b0;
        core_status = IDLE_S;
        line_req = 4'b1010;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_push("post_rst_grant", S_GRANT, 64'(4'b0010));
        step();
        sb_push("post_rst_start", S_CTRL, 64'(C_START));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
